// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches from a combinational instruction
// memory into an IF/ID register, and handles stall, redirect, halt and fault.
module fetch_stage #(
  parameter int unsigned MEM_SIZE  = 1024,
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter logic [31:0] HALT_WORD = 32'h1400_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_target,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic        halted,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d;
  logic        halted_q, fault_q;
  logic [64:0] pc_last_byte_s;
  logic        pc_illegal_s;

  // 65-bit sum so a PC near 2^64 cannot wrap into the legal range
  assign pc_last_byte_s = {1'b0, pc_q} + 65'd3;
  assign pc_illegal_s   = (pc_q[1:0] != 2'b00) || (pc_last_byte_s >= 65'(MEM_SIZE));

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    case (state_q)
      S_BOOT: begin
        if_valid_d = 1'b0;
        state_d    = S_RUN;
      end
      S_RUN: begin
        if (redirect) begin
          pc_d       = redirect_target;
          if_valid_d = 1'b0;
        end else if (pc_illegal_s) begin
          if_valid_d = 1'b0;
          state_d    = S_FAULT;
        end else if (stall) begin
          if_valid_d = if_valid_q;
        end else begin
          if_pc_d    = pc_q;
          if_instr_d = imem_instr;
          if_valid_d = 1'b1;
          if (imem_instr == HALT_WORD) begin
            state_d = S_HALT;
          end else begin
            pc_d = pc_q + 64'd4;
          end
        end
      end
      S_HALT: begin
        if (redirect) begin
          pc_d       = redirect_target;
          if_valid_d = 1'b0;
          state_d    = S_RUN;
        end else if (stall) begin
          if_valid_d = if_valid_q;
        end else begin
          // the halt word is presented for exactly one cycle
          if_valid_d = 1'b0;
        end
      end
      S_FAULT: begin
        if_valid_d = 1'b0;
      end
      default: begin
        if_valid_d = 1'b0;
        state_d    = S_FAULT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      if_pc_q    <= 64'd0;
      if_instr_q <= 32'd0;
      if_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
      halted_q   <= (state_d == S_HALT);
      fault_q    <= (state_d == S_FAULT);
    end
  end

  assign imem_addr   = pc_q;
  assign if_pc       = if_pc_q;
  assign if_instr    = if_instr_q;
  assign if_valid    = if_valid_q;
  assign halted      = halted_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random stall/redirect traffic,
// all checked against a behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam int unsigned MEM_SIZE  = 1024;
  localparam logic [31:0] HALT_WORD = 32'h1400_0000;
  localparam logic [31:0] JUNK      = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_target = 64'd0;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid, halted, fetch_fault;

  logic [31:0] mem [256];

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  logic [63:0] m_pc, m_if_pc;
  logic [31:0] m_if_instr;
  logic        m_valid, m_boot, m_halt, m_fault;

  fetch_stage #(.MEM_SIZE(MEM_SIZE), .RESET_PC(64'd0), .HALT_WORD(HALT_WORD)) dut (
    .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
    .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid),
    .halted(halted), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a < 64'(MEM_SIZE)) return mem[a[9:2]];
    return JUNK;
  endfunction

  assign imem_instr = mem_word(imem_addr);

  function automatic logic [31:0] rand_plain();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT_WORD) w = 32'h0000_0001;
    return w;
  endfunction

  function automatic bit fetch_ok(input logic [63:0] a);
    logic [64:0] last;
    last = {1'b0, a} + 65'd3;
    return (a % 64'd4 == 64'd0) && (last < 65'(MEM_SIZE));
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".imem_addr"}, imem_addr, m_pc);
    check({tag, ".if_valid"}, 64'(if_valid), 64'(m_valid));
    check({tag, ".if_pc"}, if_pc, m_if_pc);
    check({tag, ".if_instr"}, 64'(if_instr), 64'(m_if_instr));
    check({tag, ".halted"}, 64'(halted), 64'(m_halt));
    check({tag, ".fetch_fault"}, 64'(fetch_fault), 64'(m_fault));
  endtask

  task automatic model_reset();
    m_pc = 64'd0; m_if_pc = 64'd0; m_if_instr = 32'd0;
    m_valid = 1'b0; m_boot = 1'b1; m_halt = 1'b0; m_fault = 1'b0;
  endtask

  // one clock of the fetch rules, applied to the inputs as currently driven
  task automatic model_step();
    logic [31:0] w;
    if (m_fault) begin
      m_valid = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_halt) begin
      if (redirect) begin
        m_pc = redirect_target; m_valid = 1'b0; m_halt = 1'b0;
      end else if (!stall) begin
        m_valid = 1'b0;
      end
    end else if (redirect) begin
      m_pc = redirect_target; m_valid = 1'b0;
    end else if (!fetch_ok(m_pc)) begin
      m_valid = 1'b0; m_fault = 1'b1;
    end else if (!stall) begin
      w = mem_word(m_pc);
      m_if_pc = m_pc; m_if_instr = w; m_valid = 1'b1;
      if (w == HALT_WORD) m_halt = 1'b1;
      else m_pc = m_pc + 64'd4;
    end
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic s, input logic r, input logic [63:0] t);
    stall = s; redirect = r; redirect_target = t;
  endtask

  task automatic do_reset(input string tag);
    drive(1'b0, 1'b0, 64'd0);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = rand_plain();
    mem[3] = HALT_WORD;

    // reset and straight-line fetch
    #1;
    do_reset("reset");
    step("boot");
    step("seq0");
    check("seq0.if_pc_const", if_pc, 64'h0);
    step("seq4");
    check("seq4.if_pc_const", if_pc, 64'h4);

    // stall holds the IF/ID register and the PC
    drive(1'b1, 1'b0, 64'd0);
    step("stall1");
    check("stall1.addr_const", imem_addr, 64'h8);
    step("stall2");
    check("stall2.if_pc_const", if_pc, 64'h4);
    drive(1'b0, 1'b0, 64'd0);
    step("unstall");
    check("unstall.if_pc_const", if_pc, 64'h8);

    // redirect beats stall, one bubble
    drive(1'b1, 1'b1, 64'h40);
    step("redir");
    check("redir.valid_const", 64'(if_valid), 64'd0);
    check("redir.addr_const", imem_addr, 64'h40);
    drive(1'b0, 1'b0, 64'd0);
    step("redir_tgt");
    check("redir_tgt.if_pc_const", if_pc, 64'h40);

    // halt word delivered once, PC parks on it
    drive(1'b0, 1'b1, 64'h0C);
    step("to_halt");
    drive(1'b0, 1'b0, 64'd0);
    step("halt_fetch");
    check("halt_fetch.halted_const", 64'(halted), 64'd1);
    step("halt_hold1");
    step("halt_hold2");
    check("halt_hold2.addr_const", imem_addr, 64'h0C);
    drive(1'b0, 1'b1, 64'h20);
    step("halt_exit");
    drive(1'b0, 1'b0, 64'd0);
    step("halt_exit_tgt");
    check("halt_exit_tgt.if_pc_const", if_pc, 64'h20);

    // misaligned target faults two edges after redirect, sticky
    drive(1'b0, 1'b1, 64'h3FE);
    step("fault_a_redir");
    drive(1'b0, 1'b0, 64'd0);
    step("fault_a");
    check("fault_a.fault_const", 64'(fetch_fault), 64'd1);
    drive(1'b1, 1'b1, 64'h0);
    step("fault_a_sticky1");
    drive(1'b0, 1'b1, 64'h10);
    step("fault_a_sticky2");

    // target at MEM_SIZE faults likewise
    do_reset("reset2");
    step("boot2");
    drive(1'b0, 1'b1, 64'h400);
    step("fault_b_redir");
    drive(1'b0, 1'b0, 64'd0);
    step("fault_b");
    check("fault_b.fault_const", 64'(fetch_fault), 64'd1);

    // asynchronous reset while halted, between edges
    do_reset("reset3");
    step("boot3");
    drive(1'b0, 1'b1, 64'h0C);
    step("h3_redir");
    drive(1'b0, 1'b0, 64'd0);
    step("h3_fetch");
    step("h3_hold");
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    check("async_rst.halted_const", 64'(halted), 64'd0);
    #1;
    reset_n = 1'b1;

    // random traffic with sprinkled halt words and occasional bad targets
    for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 15) == 0) ? HALT_WORD : rand_plain();
    step("rnd_boot");
    for (int n = 0; n < 600; n++) begin
      logic [63:0] t;
      if (m_fault && $urandom_range(0, 3) == 0) begin
        do_reset("rnd_reset");
      end
      case ($urandom_range(0, 19))
        0:       t = 64'($urandom_range(0, 1100));
        1:       t = 64'hFFFF_FFFF_FFFF_FFFC;
        default: t = 64'($urandom_range(0, 255)) << 2;
      endcase
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, t);
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
